// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
interface data_cache_if;
  // CPU side
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  // Memory side
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  // Cache view
  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  // CPU/memory environment view
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 bytes.
// Read hits return data combinationally; misses write back a dirty victim,
// fetch the block, install it in UPDATE and then resolve as a hit.
module data_cache (
  input  logic         CLK,
  input  logic         RESET,
  data_cache_if.slave  bus
);

  localparam int unsigned LINES  = 8;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BLK_W  = 32;
  localparam int unsigned MADR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Line storage
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [BLK_W-1:0] data_mem [LINES];

  // Request decode
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             req;

  // Selected line
  logic [TAG_W-1:0]  line_tag;
  logic [BLK_W-1:0]  line_data;
  logic              line_valid;
  logic              line_dirty;
  logic              hit;
  logic [BYTE_W-1:0] sel_byte;

  // Update enables
  logic write_hit_en;
  logic fill_en;

  // Combinational outputs
  logic              busywait;
  logic [BYTE_W-1:0] readdata;
  logic              mem_read;
  logic              mem_write;
  logic [MADR_W-1:0] mem_address;
  logic [BLK_W-1:0]  mem_writedata;

  // Address fields and request presence
  assign req_tag = bus.address[7:5];
  assign req_idx = bus.address[4:2];
  assign req_off = bus.address[1:0];
  assign req     = bus.read | bus.write;

  // Indexed line lookup and hit detection (bitwise tag equality)
  assign line_tag   = tag_mem[req_idx];
  assign line_data  = data_mem[req_idx];
  assign line_valid = valid[req_idx];
  assign line_dirty = dirty[req_idx];
  assign hit        = line_valid & ~(|(line_tag ^ req_tag));

  // Byte select by offset: 0 -> [7:0] ... 3 -> [31:24]
  always_comb begin
    sel_byte = line_data[7:0];
    case (req_off)
      2'd0:    sel_byte = line_data[7:0];
      2'd1:    sel_byte = line_data[15:8];
      2'd2:    sel_byte = line_data[23:16];
      2'd3:    sel_byte = line_data[31:24];
      default: sel_byte = line_data[7:0];
    endcase
  end

  // A store takes priority over a load when both are requested
  assign write_hit_en = (state == IDLE) & bus.write & hit;
  assign fill_en      = (state == UPDATE);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next    = state;
    busywait      = 1'b0;
    readdata      = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        busywait = req & ~hit;
        if (hit) begin
          readdata = sel_byte;
        end
        if (req && !hit) begin
          state_next = (line_valid && line_dirty) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {line_tag, req_idx};
        mem_writedata = line_data;
        if (!bus.mem_busywait) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {req_tag, req_idx};
        if (!bus.mem_busywait) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        busywait   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line status bits: cleared by reset, set on fill, dirtied on write hit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[req_idx] <= 1'b1;
      dirty[req_idx] <= 1'b0;
    end else if (write_hit_en) begin
      dirty[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: block install on fill, byte merge on write hit
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= bus.mem_readdata;
    end else if (write_hit_en) begin
      data_mem[req_idx][{req_off, 3'b000} +: BYTE_W] <= bus.writedata;
    end
  end

  // Drive the bundle
  assign bus.busywait      = busywait;
  assign bus.readdata      = readdata;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_address   = mem_address;
  assign bus.mem_writedata = mem_writedata;

endmodule
